// File: rtl/inst_mem_sync.sv
// ============================================================================
// Module   : inst_mem_sync
// Summary  : Registered-read instruction memory with program-load mode,
//            fetch handshake, stall hold, fetch error flagging and a
//            saturating fetch counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_mem_sync #(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 32,
   parameter int                DEPTH    = 1024,
   parameter logic [DATA_W-1:0] NOP_WORD = '0,
   localparam int               IDX_W    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_mode,
   input  logic              prog_we,
   input  logic [IDX_W-1:0]  prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] pc,
   input  logic              stall,
   output logic [DATA_W-1:0] inst_out,
   output logic              inst_valid,
   output logic              fetch_err,
   output logic              in_run,
   output logic [31:0]       fetch_cnt
);

   localparam logic [0:0] C_ST_LOAD = 1'b0;
   localparam logic [0:0] C_ST_RUN  = 1'b1;

   logic [0:0]        r_state;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_inst_out;
   logic              r_inst_valid;
   logic              r_fetch_err;
   logic [31:0]       r_fetch_cnt;

   logic              w_in_run;
   logic              w_misaligned;
   logic              w_out_of_range;
   logic              w_err;
   logic              w_accept;
   logic [IDX_W-1:0]  w_idx;

   assign w_in_run     = (r_state == C_ST_RUN);
   assign w_misaligned = |pc[1:0];
   assign w_idx        = pc[IDX_W+1:2];
   assign w_err        = w_misaligned | w_out_of_range;
   // A request on the RUN->LOAD edge is dropped along with the mode change.
   assign w_accept     = w_in_run & ~load_mode & fetch_req & ~stall;

   generate
      if (ADDR_W > IDX_W + 2) begin : g_range_check
         assign w_out_of_range = |pc[ADDR_W-1:IDX_W+2];
      end else begin : g_no_range_check
         assign w_out_of_range = 1'b0;
      end
   endgenerate

   // Array carries no reset so a loaded program survives reset.
   always_ff @(posedge clk) begin
      if ((r_state == C_ST_LOAD) && prog_we) begin
         r_mem[prog_addr] <= prog_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= C_ST_LOAD;
         r_inst_out   <= '0;
         r_inst_valid <= 1'b0;
         r_fetch_err  <= 1'b0;
         r_fetch_cnt  <= '0;
      end else begin
         r_state <= load_mode ? C_ST_LOAD : C_ST_RUN;

         if (!w_in_run || load_mode) begin
            r_inst_valid <= 1'b0;
         end else if (!stall) begin
            if (fetch_req) begin
               r_inst_valid <= 1'b1;
               r_fetch_err  <= w_err;
               r_inst_out   <= w_err ? NOP_WORD : r_mem[w_idx];
            end else begin
               r_inst_valid <= 1'b0;
            end
         end

         if (w_accept && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
         end
      end
   end

   assign inst_out   = r_inst_out;
   assign inst_valid = r_inst_valid;
   assign fetch_err  = r_fetch_err;
   assign in_run     = w_in_run;
   assign fetch_cnt  = r_fetch_cnt;

endmodule

`default_nettype wire
